stall_fifo: RTL
===============

# stall_fifo

Elastic output buffer directly downstream of the stall-compacting shift buffer in the PMA datapath. Captures the shift buffer's `out`/`out_valid` stream, presents it to the consumer through a show-ahead valid/ready interface, and drives the shift buffer's `i_stall` when its fill level reaches a threshold. Stall is derived only from registered state, so there is no combinational path from `i_ready` back into the shift buffer.

## Interface
- `p_width`, 32, data word width; matches the shift buffer width.
- `p_depth`, 8, number of entries; power of two, at least 2.
- `p_stall_level`, `p_depth`, fill level at or above which `o_stall` asserts; range 1..`p_depth`.

- `i_clk` in 1: single clock; all state changes on the rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `in` in `p_width`: data from the shift buffer `out`.
- `in_valid` in 1: from the shift buffer `out_valid`.
- `o_stall` out 1: to the shift buffer `i_stall`; while high, no word is captured.
- `o_data` out `p_width`: head-of-queue word; forced to 0 when `o_valid`=0.
- `o_valid` out 1: queue is non-empty.
- `i_ready` in 1: consumer accepts the head this cycle.
- `o_level` out `$clog2(p_depth)+1`: current fill count, 0..`p_depth`.

## Operation
- Push: `push = in_valid & ~o_stall`. Writes `in` at `wr_ptr`, then increments `wr_ptr` modulo `p_depth`.
- Pop: `pop = o_valid & i_ready`. Increments `rd_ptr` modulo `p_depth`.
- `o_valid` = (`count` != 0). `o_data` = `mem[rd_ptr]` when valid, otherwise 0.
- Count update:
  - push and no pop: +1.
  - pop and no push: -1.
  - both, or neither: unchanged.
- `o_stall` = (`count` >= `p_stall_level`). It is a combinational decode of the `count` register only. It does not depend on `in_valid` or `i_ready`.
- While `o_stall`=1, the shift buffer holds its head stage, so `in`/`in_valid` stay constant. The block ignores them, so the word is never duplicated or lost.
- Full with a pop in the same cycle: `o_stall` stays 1 for that cycle and no push occurs. The next cycle sees `count`=`p_depth`-1, and `o_stall` drops if below `p_stall_level`.
- Empty with `i_ready`=1: no pop, and pointers do not move.
- `i_ready` while `o_valid`=0 has no effect.
- Pointers carry no wrap bit; fullness comes from `count` alone.
- Reset: `count`=0, `wr_ptr`=0, `rd_ptr`=0. Consequently `o_valid`=0, `o_data`=0, `o_stall`=0, `o_level`=0. Memory contents are not reset.
- Reset mid-operation discards all queued words. No output glitches to a stale valid after reset.

## Timing
- Push latency: a word pushed on edge N appears on `o_data` with `o_valid`=1 after edge N, i.e. in cycle N+1. There is no fall-through in the same cycle.
- Pop: the head advances after the edge on which `pop`=1. The next word, if any, is visible in the following cycle.
- `o_stall` responds one cycle after the push that raises `count` to `p_stall_level`.
- With `p_stall_level`=`p_depth`, the queue never overflows. The push that fills the queue is the last one accepted until a pop occurs.
- Throughput: one push and one pop per cycle in steady state. The queue sustains full rate whenever `0 < count < p_stall_level`.
- All outputs except `o_data` come from registers or a decode of registers. `o_data` is a memory read mux on `rd_ptr`.

## Structure
- No shared package is needed. Pointer width `$clog2(p_depth)` and count width are local parameters.
- One natural sub-module: `stall_fifo_mem`, a `p_depth` x `p_width` register array. It has one synchronous write port and one asynchronous read port, with no reset.
- Top level holds the pointers, count, stall decode and output masking.

## Test plan
- Reset, then idle:
  - After `i_rst`=1 for 2 cycles: `o_valid`=0, `o_data`=0, `o_stall`=0, `o_level`=0.
  - With `i_ready`=1 for 5 cycles, nothing changes.
- Single word: push 0xDEADBEEF on cycle 3.
  - Cycle 4: `o_valid`=1, `o_data`=0xDEADBEEF, `o_level`=1.
  - Pop on cycle 4; cycle 5: `o_valid`=0, `o_data`=0.
- Fill to stall (`p_depth`=8, `p_stall_level`=8, `i_ready`=0): push 1..10 on consecutive cycles.
  - `o_stall` rises after the 8th push; `in`=9 is held, not captured.
  - Assert `i_ready`: pops 1..8 in order, then 9 and 10 are captured without loss or duplication.
- Simultaneous push/pop at full: with `count`=8, hold `i_ready`=1 and `in_valid`=1.
  - The pop cycle captures nothing; `o_level` goes 7, then 7 steady.
  - Output order is strictly increasing.
- Wrap-around: stream 0..99 with `i_ready` toggled on a pseudo-random pattern.
  - All 100 words emerge in order.
  - `o_level` never exceeds 8.
  - `o_stall` is never high while `o_level` < 8.
- Reset mid-operation: with `o_level`=5, assert `i_rst` for 1 cycle.
  - Next cycle: `o_level`=0, `o_valid`=0.
  - A subsequent push of 0x1 emerges as the first word.

Source files
------------

// File: rtl/stall_fifo_mem.sv
// Register-array storage for stall_fifo: one synchronous write port and one
// asynchronous read port. Contents are deliberately left unreset; the top
// level masks the read data whenever the queue is empty.
module stall_fifo_mem #(
  parameter int p_width = 32,
  parameter int p_depth = 8,
  localparam int PW     = $clog2(p_depth)
) (
  input  logic               i_clk,
  input  logic               we,
  input  logic [PW-1:0]      waddr,
  input  logic [p_width-1:0] wdata,
  input  logic [PW-1:0]      raddr,
  output logic [p_width-1:0] rdata
);

  logic [p_width-1:0] mem [p_depth];

  // Write the incoming word at the write pointer on an accepted push.
  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stall_fifo.sv
// Elastic show-ahead buffer behind the stall-compacting shift buffer.
// Fill level is tracked by an explicit counter; the pointers carry no wrap
// bit. o_stall is a pure decode of the count register, so i_ready never has a
// combinational path back into the shift buffer.
module stall_fifo #(
  parameter int p_width       = 32,
  parameter int p_depth       = 8,
  parameter int p_stall_level = p_depth
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [p_width-1:0]         in,
  input  logic                       in_valid,
  output logic                       o_stall,
  output logic [p_width-1:0]         o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(p_depth):0]   o_level
);

  localparam int PW = $clog2(p_depth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] STALL_LVL = CW'(p_stall_level);

  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               push, pop;
  logic [p_width-1:0] rd_data;

  // While stalled the shift buffer holds its head word, so ignoring in_valid
  // here is what keeps that word from being duplicated or lost.
  assign o_stall = (count >= STALL_LVL);
  assign o_valid = (count != '0);
  assign push    = in_valid & ~o_stall;
  assign pop     = o_valid & i_ready;
  assign o_level = count;
  assign o_data  = o_valid ? rd_data : '0;

  // Pointer and fill-count bookkeeping; p_depth is a power of two so the
  // pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  stall_fifo_mem #(
    .p_width (p_width),
    .p_depth (p_depth)
  ) u_mem (
    .i_clk (i_clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule
